line_fill_memory: RTL and testbench

LINE_FILL_MEMORY -- requirements
Module: line_fill_memory

---
 rtl/line_fill_memory.sv | 178 +++++++++++++++++
 tb/tb_line_fill_memory.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_fill_memory.sv
// line_fill_memory
//   Backing store for an instruction cache. On a miss the cache presents a
//   byte address; the block returns the enclosing 16-byte line (four 32-bit
//   words) as a one-cycle pulse exactly LATENCY cycles after the request is
//   accepted. Memory contents are loaded through a separate write port,
//   which is usable in any state and is never cleared by reset.
//
// Parameters
//   MEM_WORDS  number of 32-bit words stored (power of two, at least 4)
//   LATENCY    cycles from request accept to line_valid (5 or more)
//
// Ports
//   clock         single clock, rising edge
//   reset         synchronous, active-high
//   req_valid     line-fill request from the cache
//   req_address   byte address of the missed instruction
//   req_ready     high only while idle; accept = req_valid & req_ready
//   line_valid    one-cycle pulse: data_line / line_address are valid
//   data_line     returned line, word k in bits [32k+31:32k]
//   line_address  16-byte-aligned base address of the returned line
//   busy          high whenever a fill is in flight
//   wr_en         preload write strobe
//   wr_addr       preload word index
//   wr_data       preload data
module line_fill_memory #(
  parameter int MEM_WORDS = 256,
  parameter int LATENCY   = 5
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         req_valid,
  input  logic [63:0]                  req_address,
  output logic                         req_ready,
  output logic                         line_valid,
  output logic [127:0]                 data_line,
  output logic [63:0]                  line_address,
  output logic                         busy,
  input  logic                         wr_en,
  input  logic [$clog2(MEM_WORDS)-1:0] wr_addr,
  input  logic [31:0]                  wr_data
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = $clog2(LATENCY);

  // The counter runs from 0 on the cycle after accept. RESP must be the
  // state during the cycle that closes at edge accept+LATENCY, so the
  // transition into RESP happens at the edge where the counter reads
  // LATENCY-2. With LATENCY=5 that coincides with the last FETCH cycle.
  localparam logic [CNT_W-1:0] RESP_AT = CNT_W'(LATENCY - 2);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    RESP
  } state_t;

  state_t state_reg, state_next;

  logic [CNT_W-1:0] cnt_reg;
  logic [59:0]      base_reg;          // line base address bits [63:4]
  logic [127:0]     data_line_reg;
  logic [63:0]      line_address_reg;

  logic [31:0]      mem [MEM_WORDS];
  logic [31:0]      buf_reg [4];       // line buffer, slot k = word k

  logic [63:0]      base_addr;
  logic [IDX_W-1:0] base_idx;
  logic [1:0]       word_k;
  logic [IDX_W-1:0] rd_addr;
  logic [31:0]      rd_word;
  logic             fetching;
  logic [127:0]     line_next;
  logic             unused_addr_bits;

  // The byte offset within a line never affects the result.
  assign unused_addr_bits = ^req_address[3:0];

  assign base_addr = {base_reg, 4'b0000};
  assign base_idx  = base_addr[IDX_W+1:2];
  assign word_k    = cnt_reg[1:0];
  assign fetching  = (state_reg == FETCH);

  // Bits of the address above the index are simply dropped, so high
  // addresses alias onto the array; the sum wraps modulo MEM_WORDS.
  assign rd_addr = base_idx + IDX_W'(word_k);
  assign rd_word = mem[rd_addr];

  // Preload port. Non-blocking update means a FETCH read of the same word
  // on the same edge still sees the old contents.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read data is only ever consumed through registers: the line buffer
  // here and the output line register below.
  always_ff @(posedge clock) begin
    if (fetching) begin
      buf_reg[word_k] <= rd_word;
    end
  end

  // Line as it will be once the current edge completes: the word being
  // fetched this cycle bypasses the buffer. This lets LATENCY=5 present
  // the full line in RESP even though word 3 lands on the RESP entry edge.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_line
      assign line_next[32*gi +: 32] =
        (fetching && (word_k == 2'(gi))) ? rd_word : buf_reg[gi];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (word_k == 2'd3) begin
          state_next = (cnt_reg == RESP_AT) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_reg == RESP_AT) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      base_reg         <= '0;
      data_line_reg    <= '0;
      line_address_reg <= '0;
    end else begin
      state_reg <= state_next;

      if (state_reg == IDLE) begin
        cnt_reg <= '0;
        if (req_valid) begin
          base_reg <= req_address[63:4];
        end
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end

      // Outputs change only when a new line is presented, so they hold
      // the last response until the next one.
      if ((state_next == RESP) && (state_reg != RESP)) begin
        data_line_reg    <= line_next;
        line_address_reg <= base_addr;
      end
    end
  end

  assign req_ready    = (state_reg == IDLE);
  assign busy         = (state_reg != IDLE);
  assign line_valid   = (state_reg == RESP);
  assign data_line    = data_line_reg;
  assign line_address = line_address_reg;

endmodule

// File: tb/tb_line_fill_memory.sv
// Directed bench for line_fill_memory. Two instances share clock, reset
// and the preload port: one with LATENCY=5, one with LATENCY=8.
// All driving and sampling happen 1 time unit after a rising edge. "After
// edge N+c" below is the value visible during the cycle that closes at
// edge N+c+1, where N is the accept edge.
module tb_line_fill_memory;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;

  logic         req_valid5, req_ready5, line_valid5, busy5;
  logic [63:0]  req_address5, line_address5;
  logic [127:0] data_line5;

  logic         req_valid8, req_ready8, line_valid8, busy8;
  logic [63:0]  req_address8, line_address8;
  logic [127:0] data_line8;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] LINE_A   = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [127:0] LINE_TOP = {32'hF00000FF, 32'hF00000FE, 32'hF00000FD, 32'hF00000FC};

  line_fill_memory #(.MEM_WORDS(256), .LATENCY(5)) dut5 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid5), .req_address(req_address5), .req_ready(req_ready5),
    .line_valid(line_valid5), .data_line(data_line5), .line_address(line_address5),
    .busy(busy5), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  line_fill_memory #(.MEM_WORDS(256), .LATENCY(8)) dut8 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid8), .req_address(req_address8), .req_ready(req_ready8),
    .line_valid(line_valid8), .data_line(data_line8), .line_address(line_address8),
    .busy(busy8), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_word(input logic [7:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  // Reset state; a request held during reset must not be accepted.
  task automatic test_reset();
    reset        = 1'b1;
    req_valid5   = 1'b1;
    req_address5 = 64'h18;
    tick();
    tick();
    reset      = 1'b0;
    req_valid5 = 1'b0;
    n_checks++;
    if (req_ready5 !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready5); end
    n_checks++;
    if (line_valid5 !== 1'b0) begin n_fail++; $display("FAIL reset_line_valid: got %b want 0", line_valid5); end
    n_checks++;
    if (busy5 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy5); end
    n_checks++;
    if (data_line5 !== 128'h0) begin n_fail++; $display("FAIL reset_data_line: got %h want 0", data_line5); end
    n_checks++;
    if (line_address5 !== 64'h0) begin n_fail++; $display("FAIL reset_line_address: got %h want 0", line_address5); end
    n_checks++;
    if (busy8 !== 1'b0 || req_ready8 !== 1'b1) begin
      n_fail++; $display("FAIL reset_dut8: got busy=%b ready=%b want 0/1", busy8, req_ready8);
    end
    tick();
    n_checks++;
    if (busy5 !== 1'b0) begin n_fail++; $display("FAIL reset_req_ignored: got busy=%b want 0", busy5); end
    $display("reset done");
  endtask

  task automatic preload();
    write_word(8'd4, 32'h11111111);
    write_word(8'd5, 32'h22222222);
    write_word(8'd6, 32'h33333333);
    write_word(8'd7, 32'h44444444);
    for (int i = 0; i < 4; i++) begin
      write_word(8'(252 + i), 32'hF00000FC + 32'(i));
    end
    $display("preload done");
  endtask

  // Single fill at 0x18: pulse only in the cycle after edge N+4.
  task automatic test_basic();
    logic exp_lv;
    req_valid5   = 1'b1;
    req_address5 = 64'h18;
    tick();
    req_valid5 = 1'b0;
    n_checks++;
    if (busy5 !== 1'b1 || req_ready5 !== 1'b0) begin
      n_fail++; $display("FAIL basic_accept: got busy=%b ready=%b want 1/0", busy5, req_ready5);
    end
    for (int c = 1; c <= 5; c++) begin
      tick();
      exp_lv = (c == 4);
      n_checks++;
      if (line_valid5 !== exp_lv) begin
        n_fail++; $display("FAIL basic_line_valid c=%0d: got %b want %b", c, line_valid5, exp_lv);
      end
      if (c == 4) begin
        n_checks++;
        if (data_line5 !== LINE_A) begin n_fail++; $display("FAIL basic_data: got %h want %h", data_line5, LINE_A); end
        n_checks++;
        if (line_address5 !== 64'h10) begin n_fail++; $display("FAIL basic_address: got %h want 10", line_address5); end
      end
    end
    n_checks++;
    if (data_line5 !== LINE_A || line_address5 !== 64'h10) begin
      n_fail++; $display("FAIL basic_hold: got %h/%h want %h/10", data_line5, line_address5, LINE_A);
    end
    n_checks++;
    if (req_ready5 !== 1'b1) begin n_fail++; $display("FAIL basic_ready_after: got %b want 1", req_ready5); end
    $display("fill 0x18 -> line %h at %h", data_line5, line_address5);
  endtask

  // req_valid held high: second accept at N+6, pulses after N+4 and N+10.
  task automatic test_back_to_back();
    logic exp_ready, exp_lv;
    req_valid5   = 1'b1;
    req_address5 = 64'h10;
    tick();
    for (int c = 0; c <= 11; c++) begin
      if (c > 0) tick();
      exp_ready = (c == 5) || (c == 11);
      exp_lv    = (c == 4) || (c == 10);
      n_checks++;
      if (req_ready5 !== exp_ready) begin
        n_fail++; $display("FAIL b2b_ready c=%0d: got %b want %b", c, req_ready5, exp_ready);
      end
      n_checks++;
      if (line_valid5 !== exp_lv) begin
        n_fail++; $display("FAIL b2b_line_valid c=%0d: got %b want %b", c, line_valid5, exp_lv);
      end
      if (c == 10) begin
        n_checks++;
        if (data_line5 !== LINE_A) begin n_fail++; $display("FAIL b2b_data: got %h want %h", data_line5, LINE_A); end
      end
    end
    req_valid5 = 1'b0;
    tick();
    n_checks++;
    if (busy5 !== 1'b0) begin n_fail++; $display("FAIL b2b_stop: got busy=%b want 0", busy5); end
    $display("back-to-back fills at 0x10 -> line %h", data_line5);
  endtask

  // Write to word 3 before it is fetched is seen; same-edge write is not.
  task automatic test_write_during_fill();
    logic [127:0] exp_line;
    exp_line     = LINE_A;
    req_valid5   = 1'b1;
    req_address5 = 64'h10;
    tick();
    req_valid5 = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 8'd7;
    wr_data = 32'hDEADBEEF;
    tick();
    wr_en = 1'b0;
    tick();
    tick();
    tick();
    n_checks++;
    if (line_valid5 !== 1'b1) begin n_fail++; $display("FAIL wr_early_valid: got %b want 1", line_valid5); end
    n_checks++;
    if (data_line5[127:96] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL wr_early_word3: got %h want deadbeef", data_line5[127:96]);
    end
    n_checks++;
    if (data_line5[95:0] !== exp_line[95:0]) begin
      n_fail++; $display("FAIL wr_early_low: got %h want %h", data_line5[95:0], exp_line[95:0]);
    end
    $display("fill 0x10 with early write -> line %h", data_line5);
    tick();
    write_word(8'd7, 32'h44444444);

    req_valid5 = 1'b1;
    tick();
    req_valid5 = 1'b0;
    tick();
    tick();
    tick();
    wr_en   = 1'b1;
    wr_addr = 8'd7;
    wr_data = 32'hDEADBEEF;
    tick();
    wr_en = 1'b0;
    n_checks++;
    if (line_valid5 !== 1'b1) begin n_fail++; $display("FAIL wr_late_valid: got %b want 1", line_valid5); end
    n_checks++;
    if (data_line5[127:96] !== 32'h44444444) begin
      n_fail++; $display("FAIL wr_late_word3: got %h want 44444444", data_line5[127:96]);
    end
    $display("fill 0x10 with same-edge write -> line %h", data_line5);
    tick();
    write_word(8'd7, 32'h44444444);
  endtask

  // Reset at edge N+3 aborts the fill; memory survives.
  task automatic test_reset_abort();
    req_valid5   = 1'b1;
    req_address5 = 64'h10;
    tick();
    req_valid5 = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (line_valid5 !== 1'b0) begin n_fail++; $display("FAIL abort_line_valid: got %b want 0", line_valid5); end
    n_checks++;
    if (data_line5 !== 128'h0) begin n_fail++; $display("FAIL abort_data: got %h want 0", data_line5); end
    n_checks++;
    if (req_ready5 !== 1'b1 || busy5 !== 1'b0) begin
      n_fail++; $display("FAIL abort_state: got ready=%b busy=%b want 1/0", req_ready5, busy5);
    end
    for (int c = 4; c <= 7; c++) begin
      tick();
      n_checks++;
      if (line_valid5 !== 1'b0) begin n_fail++; $display("FAIL abort_no_pulse c=%0d: got %b want 0", c, line_valid5); end
    end
    req_valid5 = 1'b1;
    tick();
    req_valid5 = 1'b0;
    for (int c = 1; c <= 4; c++) tick();
    n_checks++;
    if (line_valid5 !== 1'b1 || data_line5 !== LINE_A) begin
      n_fail++; $display("FAIL abort_refill: got valid=%b data=%h want 1/%h", line_valid5, data_line5, LINE_A);
    end
    $display("refill after abort -> line %h", data_line5);
    tick();
  endtask

  // LATENCY=8: top-of-memory line and an aliased high address.
  task automatic test_latency8();
    logic exp_lv, exp_busy;
    req_valid8   = 1'b1;
    req_address8 = 64'hFF0;
    tick();
    req_valid8 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      exp_lv   = (c == 7);
      exp_busy = (c <= 7);
      n_checks++;
      if (line_valid8 !== exp_lv) begin
        n_fail++; $display("FAIL l8_line_valid c=%0d: got %b want %b", c, line_valid8, exp_lv);
      end
      n_checks++;
      if (busy8 !== exp_busy) begin
        n_fail++; $display("FAIL l8_busy c=%0d: got %b want %b", c, busy8, exp_busy);
      end
      if (c == 7) begin
        n_checks++;
        if (data_line8 !== LINE_TOP) begin n_fail++; $display("FAIL l8_top_data: got %h want %h", data_line8, LINE_TOP); end
        n_checks++;
        if (line_address8 !== 64'hFF0) begin n_fail++; $display("FAIL l8_top_address: got %h want ff0", line_address8); end
      end
    end
    $display("fill 0xff0 (latency 8) -> line %h", data_line8);

    req_valid8   = 1'b1;
    req_address8 = 64'h101C;
    tick();
    req_valid8 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 7) begin
        n_checks++;
        if (line_valid8 !== 1'b1 || data_line8 !== LINE_A) begin
          n_fail++; $display("FAIL l8_alias_data: got valid=%b data=%h want 1/%h", line_valid8, data_line8, LINE_A);
        end
        n_checks++;
        if (line_address8 !== 64'h1010) begin
          n_fail++; $display("FAIL l8_alias_address: got %h want 1010", line_address8);
        end
      end
    end
    $display("fill 0x101c (latency 8) -> line %h at %h", data_line8, line_address8);
  endtask

  initial begin
    reset        = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    req_valid5   = 1'b0;
    req_address5 = '0;
    req_valid8   = 1'b0;
    req_address8 = '0;

    test_reset();
    preload();
    test_basic();
    test_back_to_back();
    test_write_during_fill();
    test_reset_abort();
    test_latency8();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
